stack_ctrl: RTL and testbench

Game-state writer for the burger-stack display. Owns the plate position, the stacked-slot colour vector and the falling block, and advances them once per frame tick. Its outputs drive the renderer's `pos_x`, `colors`, `fall_x`, `fall_y` and `fall_clr` inputs directly. Player buttons and a start pulse come from the board input debouncers.

---
 rtl/stack_ctrl_pkg.sv | 30 +++
 rtl/stack_ctrl_lfsr16.sv | 14 +
 rtl/stack_ctrl.sv | 141 ++++++++++++++
 tb/tb_stack_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the burger-stack game: screen geometry, colour codes
// and controller state encodings (the renderer uses the geometry and colours too).
package stack_ctrl_pkg;

  localparam logic [9:0] BASE_Y   = 10'd400;
  localparam logic [9:0] SLOT_H   = 10'd20;
  localparam logic [9:0] W        = 10'd100;
  localparam logic [9:0] X_MAX    = 10'd540;
  localparam logic [9:0] POS_INIT = 10'd270;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] RED   = 2'b10;
  localparam logic [1:0] GREEN = 2'b01;
  localparam logic [1:0] BLUE  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SPAWN = 3'd1,
    S_FALL  = 3'd2,
    S_LAND  = 3'd3,
    S_WIN   = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  // Top edge at which a falling block rests on a stack of the given height.
  function automatic logic [9:0] land_line(input logic [3:0] h);
    return BASE_Y - SLOT_H - SLOT_H * {6'd0, h};
  endfunction

endpackage

// File: rtl/stack_ctrl_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (shift left, taps 15/13/12/10); loads seed on rst.
module lfsr16 (
  input  logic        dclk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge dclk) begin
    if (rst) q <= seed;
    else     q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  end

endmodule

// File: rtl/stack_ctrl.sv
// Game-state writer for the burger-stack display: plate position, stacked colours
// and the falling block, advanced once per frame tick. State is exposed on `state`.
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int unsigned STEP      = 4,
  parameter int unsigned FALL_STEP = 2,
  parameter int unsigned MAX_MISS  = 3,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic        dclk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic [9:0]  pos_x,
  output logic [31:0] colors,
  output logic [9:0]  fall_x,
  output logic [9:0]  fall_y,
  output logic [1:0]  fall_clr,
  output logic [3:0]  height,
  output logic [1:0]  misses,
  output logic        win,
  output logic        game_over,
  output logic [2:0]  state
);

  localparam logic [9:0]        STEP_V   = 10'(STEP);
  localparam logic [9:0]        FALL_V   = 10'(FALL_STEP);
  localparam logic [1:0]        MISS_LIM = 2'(MAX_MISS);
  localparam logic signed [10:0] CATCH   = 11'(W >> 1);

  state_t      st;
  logic [15:0] lfsr;
  logic        unused_lfsr_bits;
  logic [9:0]  pos_moved;
  logic [9:0]  spawn_x;
  logic [1:0]  spawn_clr;
  logic [9:0]  land_y;
  logic [10:0] dx;
  logic        caught;
  logic [3:0]  height_inc;
  logic [1:0]  misses_inc;

  lfsr16 u_lfsr (
    .dclk (dclk),
    .rst  (rst),
    .seed (SEED),
    .q    (lfsr)
  );

  assign unused_lfsr_bits = ^lfsr[15:11];
  assign state      = st;
  assign land_y     = land_line(height);
  assign height_inc = height + 4'd1;
  assign misses_inc = misses + 2'd1;

  always_comb begin
    pos_moved = pos_x;
    if (tick && btn_left && !btn_right)
      pos_moved = (pos_x < STEP_V) ? 10'd0 : pos_x - STEP_V;
    else if (tick && btn_right && !btn_left)
      pos_moved = (pos_x > X_MAX - STEP_V) ? X_MAX : pos_x + STEP_V;

    spawn_x = {1'b0, lfsr[8:0]};
    if (spawn_x > X_MAX) spawn_x = spawn_x - 10'd256;
    spawn_clr = (lfsr[10:9] == EMPTY) ? GREEN : lfsr[10:9];

    // Catch uses the plate position from before this cycle's move.
    dx     = {1'b0, fall_x} - {1'b0, pos_x};
    caught = ($signed(dx) < CATCH) && ($signed(dx) > -CATCH);
  end

  always_ff @(posedge dclk) begin
    if (rst) begin
      st        <= S_IDLE;
      pos_x     <= POS_INIT;
      colors    <= 32'h1;
      fall_x    <= '0;
      fall_y    <= '0;
      fall_clr  <= EMPTY;
      height    <= '0;
      misses    <= '0;
      win       <= 1'b0;
      game_over <= 1'b0;
    end else begin
      case (st)
        S_IDLE, S_WIN, S_OVER: begin
          if (start) begin
            colors    <= 32'h1;
            height    <= '0;
            misses    <= '0;
            pos_x     <= POS_INIT;
            win       <= 1'b0;
            game_over <= 1'b0;
            st        <= S_SPAWN;
          end
        end
        S_SPAWN: begin
          fall_x   <= spawn_x;
          fall_y   <= '0;
          fall_clr <= spawn_clr;
          pos_x    <= pos_moved;
          st       <= S_FALL;
        end
        S_FALL: begin
          pos_x <= pos_moved;
          if (tick) begin
            if (fall_y >= land_y) st <= S_LAND;
            else                  fall_y <= fall_y + FALL_V;
          end
        end
        S_LAND: begin
          pos_x    <= pos_moved;
          fall_clr <= EMPTY;
          if (caught) begin
            colors[{height_inc, 1'b0} +: 2] <= fall_clr;
            height <= height_inc;
            if (height_inc == 4'd15) begin
              st  <= S_WIN;
              win <= 1'b1;
            end else begin
              st <= S_SPAWN;
            end
          end else begin
            misses <= misses_inc;
            if (misses_inc == MISS_LIM) begin
              st        <= S_OVER;
              game_over <= 1'b1;
            end else begin
              st <= S_SPAWN;
            end
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: a game-level model (block list, plate, miss count) predicts
// every output each cycle; directed scenarios plus randomized play drive the DUT.
module tb_stack_ctrl;
  import stack_ctrl_pkg::*;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int PH_IDLE = 0, PH_SPAWN = 1, PH_FALL = 2, PH_LAND = 3, PH_WIN = 4, PH_OVER = 5;

  typedef struct packed {
    logic [9:0]  pos;
    logic [31:0] clr_vec;
    logic [9:0]  fx;
    logic [9:0]  fy;
    logic [1:0]  fclr;
    logic [3:0]  h;
    logic [1:0]  miss;
    logic        win;
    logic        over;
    logic [2:0]  st;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic        dclk = 1'b0;
  logic        rst, tick, start, btn_left, btn_right;
  logic [9:0]  pos_x, fall_x, fall_y;
  logic [31:0] colors;
  logic [1:0]  fall_clr, misses;
  logic [3:0]  height;
  logic        win, game_over;
  logic [2:0]  state;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [EXP_W-1:0] exp_q[$];

  // Game-level model
  int          m_phase;
  logic [15:0] m_lfsr;
  int          m_pos, m_fx, m_fy, m_clr, m_misses;
  logic [1:0]  m_stack[$];

  // ---------------- clock / reset ----------------
  always #5 dclk = ~dclk;

  stack_ctrl dut (
    .dclk(dclk), .rst(rst), .tick(tick), .start(start),
    .btn_left(btn_left), .btn_right(btn_right),
    .pos_x(pos_x), .colors(colors), .fall_x(fall_x), .fall_y(fall_y),
    .fall_clr(fall_clr), .height(height), .misses(misses),
    .win(win), .game_over(game_over), .state(state)
  );

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] phase_state(input int p);
    case (p)
      PH_SPAWN: return S_SPAWN;
      PH_FALL:  return S_FALL;
      PH_LAND:  return S_LAND;
      PH_WIN:   return S_WIN;
      PH_OVER:  return S_OVER;
      default:  return S_IDLE;
    endcase
  endfunction

  function automatic logic [31:0] model_colors();
    logic [31:0] c;
    c = 32'h1;
    foreach (m_stack[i]) c[2*(i+1) +: 2] = m_stack[i];
    return c;
  endfunction

  // ---------------- reference model ----------------
  task automatic move_plate(input bit t, input bit l, input bit r);
    if (t && l && !r)      m_pos = (m_pos - 4 < 0) ? 0 : m_pos - 4;
    else if (t && r && !l) m_pos = (m_pos + 4 > 540) ? 540 : m_pos + 4;
  endtask

  task automatic model_step(input bit r, input bit s, input bit t, input bit l, input bit rt);
    logic [15:0] cur;
    int x, d;
    exp_t e;
    if (r) begin
      m_phase = PH_IDLE; m_lfsr = SEED; m_pos = 270; m_stack.delete();
      m_fx = 0; m_fy = 0; m_clr = 0; m_misses = 0;
    end else begin
      cur    = m_lfsr;
      m_lfsr = {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
      case (m_phase)
        PH_IDLE, PH_WIN, PH_OVER:
          if (s) begin
            m_stack.delete(); m_misses = 0; m_pos = 270; m_phase = PH_SPAWN;
          end
        PH_SPAWN: begin
          x = int'(cur[8:0]);
          if (x > 540) x -= 256;
          m_fx = x; m_fy = 0;
          m_clr = (cur[10:9] == 2'b00) ? 1 : int'(cur[10:9]);
          m_phase = PH_FALL;
          move_plate(t, l, rt);
        end
        PH_FALL: begin
          if (t) begin
            if (m_fy >= 380 - 20 * m_stack.size()) m_phase = PH_LAND;
            else m_fy += 2;
          end
          move_plate(t, l, rt);
        end
        default: begin
          d = m_fx - m_pos;
          if (d > -50 && d < 50) begin
            m_stack.push_back(2'(m_clr));
            m_phase = (m_stack.size() == 15) ? PH_WIN : PH_SPAWN;
          end else begin
            m_misses++;
            m_phase = (m_misses == 3) ? PH_OVER : PH_SPAWN;
          end
          m_clr = 0;
          move_plate(t, l, rt);
        end
      endcase
    end
    e.pos = 10'(m_pos); e.clr_vec = model_colors(); e.fx = 10'(m_fx); e.fy = 10'(m_fy);
    e.fclr = 2'(m_clr); e.h = 4'(m_stack.size()); e.miss = 2'(m_misses);
    e.win = (m_phase == PH_WIN); e.over = (m_phase == PH_OVER); e.st = phase_state(m_phase);
    exp_q.push_back(EXP_W'(e));
  endtask

  // ---------------- scoreboard ----------------
  task automatic compare_outputs();
    exp_t e;
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_t'(exp_q.pop_front());
    check_val("pos_x",     32'(pos_x),     32'(e.pos));
    check_val("colors",    colors,         e.clr_vec);
    check_val("fall_x",    32'(fall_x),    32'(e.fx));
    check_val("fall_y",    32'(fall_y),    32'(e.fy));
    check_val("fall_clr",  32'(fall_clr),  32'(e.fclr));
    check_val("height",    32'(height),    32'(e.h));
    check_val("misses",    32'(misses),    32'(e.miss));
    check_val("win",       32'(win),       32'(e.win));
    check_val("game_over", 32'(game_over), 32'(e.over));
    check_val("state",     32'(state),     32'(e.st));
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input bit r, input bit s, input bit t, input bit l, input bit rt);
    rst = r; start = s; tick = t; btn_left = l; btn_right = rt;
    model_step(r, s, t, l, rt);
    @(posedge dclk);
    @(negedge dclk);
    compare_outputs();
  endtask

  task automatic steer(output bit l, output bit r);
    int tgt;
    tgt = (m_fx < 270) ? m_fx + 30 : m_fx - 30;
    l = (m_pos > tgt + 4);
    r = (m_pos + 4 < tgt);
  endtask

  task automatic start_if_stopped();
    if (m_phase == PH_IDLE || m_phase == PH_WIN || m_phase == PH_OVER)
      drive_cycle(0, 1, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit l, r;
    rst = 1'b1; start = 1'b0; tick = 1'b0; btn_left = 1'b0; btn_right = 1'b0;

    drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(1, 0, 0, 0, 0);
    check_val("rst_pos_x",  32'(pos_x), 32'd270);
    check_val("rst_colors", colors, 32'h1);
    check_val("rst_clr",    32'(fall_clr), 32'd0);

    repeat (10) drive_cycle(0, 0, 1, 0, 0);
    check_val("idle_state", 32'(state), 32'(S_IDLE));

    // Plate clamps at both screen edges; both buttons freeze it.
    drive_cycle(0, 1, 0, 0, 0);
    repeat (80)  drive_cycle(0, 0, 1, 1, 0);
    check_val("clamp_left", 32'(pos_x), 32'd0);
    repeat (150) drive_cycle(0, 0, 1, 0, 1);
    check_val("clamp_right", 32'(pos_x), 32'd540);
    repeat (20)  drive_cycle(0, 0, 1, 1, 1);
    check_val("both_held", 32'(pos_x), 32'd540);

    // Plate parked at the left edge until three misses end the game.
    for (int i = 0; i < 20000 && m_phase != PH_OVER; i++) drive_cycle(0, 0, 1, 1, 0);
    check_val("over_flag",   32'(game_over), 32'd1);
    check_val("over_misses", 32'(misses), 32'd3);
    for (int i = 0; i < 20; i++) drive_cycle(0, 0, 1, $urandom_range(0, 1), $urandom_range(0, 1));

    // Steer under every block until a game is won.
    for (int g = 0; g < 8 && m_phase != PH_WIN; g++) begin
      start_if_stopped();
      for (int i = 0; i < 6000 && m_phase != PH_WIN && m_phase != PH_OVER; i++) begin
        steer(l, r);
        drive_cycle(0, 0, 1, l, r);
      end
    end
    if (m_phase == PH_WIN) begin
      check_val("win_flag",   32'(win), 32'd1);
      check_val("win_height", 32'(height), 32'd15);
      for (int k = 1; k < 16; k++) check_val("slot_filled", 32'(colors[2*k +: 2] != 2'b00), 32'd1);
      drive_cycle(0, 1, 0, 0, 0);
      check_val("restart_colors", colors, 32'h1);
    end

    // Reset mid-fall, with start held high alongside it.
    start_if_stopped();
    for (int i = 0; i < 500 && !(m_phase == PH_FALL && m_fy == 100); i++) drive_cycle(0, 0, 1, 0, 0);
    check_val("fall_y_100", 32'(fall_y), 32'd100);
    drive_cycle(1, 1, 1, 0, 0);
    check_val("midrst_pos",    32'(pos_x), 32'd270);
    check_val("midrst_colors", colors, 32'h1);
    check_val("midrst_fall_y", 32'(fall_y), 32'd0);
    check_val("midrst_state",  32'(state), 32'(S_IDLE));
    drive_cycle(1, 1, 0, 0, 0);
    check_val("rst_beats_start", 32'(state), 32'(S_IDLE));

    // Randomized play.
    for (int i = 0; i < 6000; i++)
      drive_cycle($urandom_range(0, 999) == 0, $urandom_range(0, 149) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
